ysyx_23060236_lsu: RTL and testbench

YSYX_23060236_LSU -- requirements
Module: ysyx_23060236_lsu
Interface
REQ-001 clock  input  1  sole clock, all flops rising-edge.
REQ-002 reset  input  1  asynchronous active-low reset.
REQ-003 lsu_valid  input  1  one-cycle start pulse from the execute stage, accepted only in IDLE.
REQ-004 lsu_ren  input  1  load; sampled with lsu_valid.
REQ-005 lsu_wen  input  1  store; sampled with lsu_valid; never asserted together with lsu_ren.
REQ-006 funct3  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address, which is the execute-stage ALU sum.
REQ-008 store_data  input  32  rs2 value, LSB-aligned.
REQ-009 lsu_over  output  1  one-cycle completion pulse to the execute stage.
REQ-010 lsu_rdata  output  32  extended load result, valid while lsu_over=1.
REQ-011 lsu_err  output  1  access fault, valid while lsu_over=1.
REQ-012 araddr  output  32  read address.
REQ-013 arvalid  output  1  read address valid.
REQ-014 arready  input  1  read address ready.
REQ-015 rdata  input  32  read data, word-aligned lanes.
REQ-016 rresp  input  2  read response, where 00 is OKAY.
REQ-017 rvalid  input  1  read data valid.
REQ-018 rready  output  1  read data ready.
REQ-019 awaddr  output  32  write address.
REQ-020 awvalid  output  1  write address valid.
REQ-021 awready  input  1  write address ready.
REQ-022 wdata  output  32  write data, lane-shifted by addr[1:0].
REQ-023 wstrb  output  4  byte strobes.
REQ-024 wvalid  output  1  write data valid.
REQ-025 wready  input  1  write data ready.
REQ-026 bresp  input  2  write response, where 00 is OKAY.
REQ-027 bvalid  input  1  write response valid.
REQ-028 bready  output  1  write response ready.

---
 rtl/ysyx_23060236_lsu.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_23060236_lsu.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_lsu.sv
// Load/store unit: turns one execute-stage request into an AXI-Lite style read or write.
// Optional macro LSU_MISALIGN_CHECK_EN faults misaligned H/W accesses without touching the bus.
module ysyx_23060236_lsu (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_valid,
  input  logic        lsu_ren,
  input  logic        lsu_wen,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        lsu_over,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WREQ,
    WRESP,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        misalign;
  logic [4:0]  lane_shift;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;
  logic [3:0]  strb_sel;

  assign lane_shift = {addr_q[1:0], 3'b000};

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign = addr[0];
      2'b10:   misalign = |addr[1:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Load data arrives in word lanes; bring the addressed byte down to bit 0 before extending.
  always_comb begin
    rdata_shifted = rdata >> lane_shift;
    case (funct3_q)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_ext = {24'b0, rdata_shifted[7:0]};
      3'b101:  load_ext = {16'b0, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   strb_sel = 4'b0001 << addr_q[1:0];
      2'b01:   strb_sel = 4'b0011 << addr_q[1:0];
      default: strb_sel = 4'b1111;
    endcase
  end

  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign wdata   = store_data_q << lane_shift;
  assign wstrb   = strb_sel;
  assign arvalid = (state_q == RADDR);
  assign rready  = (state_q == RDATA);
  assign awvalid = (state_q == WREQ) && !aw_done_q;
  assign wvalid  = (state_q == WREQ) && !w_done_q;
  assign bready  = (state_q == WRESP);

  assign lsu_over  = (state_q == DONE);
  assign lsu_err   = (state_q == DONE) && err_q;
  assign lsu_rdata = (state_q == DONE) ? rdata_q : 32'b0;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    store_data_d = store_data_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    case (state_q)
      IDLE: begin
        if (lsu_valid) begin
          addr_d       = addr;
          funct3_d     = funct3;
          store_data_d = store_data;
          rdata_d      = 32'b0;
          err_d        = 1'b0;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          if ((lsu_ren || lsu_wen) && misalign) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (lsu_ren) begin
            state_d = RADDR;
          end else if (lsu_wen) begin
            state_d = WREQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      RADDR: begin
        if (arready) state_d = RADDR == RADDR ? RDATA : RADDR;
      end
      RDATA: begin
        if (rvalid) begin
          rdata_d = load_ext;
          err_d   = |rresp;
          state_d = DONE;
        end
      end
      // Address and data channels retire independently; leave once both have handshaken.
      WREQ: begin
        if (awready) aw_done_d = 1'b1;
        if (wready)  w_done_d  = 1'b1;
        if ((aw_done_q || awready) && (w_done_q || wready)) state_d = WRESP;
      end
      WRESP: begin
        if (bvalid) begin
          err_d   = |bresp;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= 32'b0;
      funct3_q     <= 3'b0;
      store_data_q <= 32'b0;
      rdata_q      <= 32'b0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      store_data_q <= store_data_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_lsu.sv
// Scoreboard bench for ysyx_23060236_lsu: directed requests, a bus responder, and a monitor
// that checks every completion pulse and the reset state.
module tb_ysyx_23060236_lsu;

  logic        clock;
  logic        reset;
  logic        lsu_valid;
  logic        lsu_ren;
  logic        lsu_wen;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        lsu_over;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  ysyx_23060236_lsu dut (
    .clock      (clock),
    .reset      (reset),
    .lsu_valid  (lsu_valid),
    .lsu_ren    (lsu_ren),
    .lsu_wen    (lsu_wen),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .lsu_over   (lsu_over),
    .lsu_rdata  (lsu_rdata),
    .lsu_err    (lsu_err),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready)
  );

  typedef struct {
    int          kind;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          issue;
    int          ar_snap;
    int          aw_snap;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  int          ar_delay   = 0;
  int          r_delay    = 0;
  int          aw_delay   = 0;
  int          w_delay    = 0;
  int          b_delay    = 0;
  logic [31:0] r_data_cfg = 32'h0;
  logic [1:0]  r_resp_cfg = 2'b00;
  logic [1:0]  b_resp_cfg = 2'b00;

  logic [31:0] cap_araddr;
  logic [31:0] cap_awaddr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  int          ar_seen;
  int          aw_seen;
  int          last_resp_cycle;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Bus responder: readies are decided on the falling edge for the next rising edge.
  initial begin
    int ar_w, r_w, aw_w, w_w, b_w;
    ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    cap_araddr = 0; cap_awaddr = 0; cap_wdata = 0; cap_wstrb = 0;
    ar_seen = 0; aw_seen = 0; last_resp_cycle = -10;
    forever begin
      @(negedge clock);
      if (!reset) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
      end else begin
        if (arvalid) begin
          ar_seen++;
          if (ar_w >= ar_delay) begin arready = 1; cap_araddr = araddr; end
          else begin arready = 0; ar_w++; end
        end else begin arready = 0; ar_w = 0; end
        if (rready) begin
          if (r_w >= r_delay) begin
            rvalid = 1; rdata = r_data_cfg; rresp = r_resp_cfg; last_resp_cycle = cycle;
          end else begin rvalid = 0; r_w++; end
        end else begin rvalid = 0; r_w = 0; end
        if (awvalid) begin
          aw_seen++;
          if (aw_w >= aw_delay) begin awready = 1; cap_awaddr = awaddr; end
          else begin awready = 0; aw_w++; end
        end else begin awready = 0; aw_w = 0; end
        if (wvalid) begin
          if (w_w >= w_delay) begin wready = 1; cap_wdata = wdata; cap_wstrb = wstrb; end
          else begin wready = 0; w_w++; end
        end else begin wready = 0; w_w = 0; end
        if (bready) begin
          if (b_w >= b_delay) begin
            bvalid = 1; bresp = b_resp_cfg; last_resp_cycle = cycle;
          end else begin bvalid = 0; b_w++; end
        end else begin bvalid = 0; b_w = 0; end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: reset-state checks while reset is low, scoreboard compare on every completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        checkOutput("rst_over",    32'(lsu_over),     32'd0);
        checkOutput("rst_err",     32'(lsu_err),      32'd0);
        checkOutput("rst_rdata",   lsu_rdata,         32'd0);
        checkOutput("rst_arvalid", 32'(arvalid),      32'd0);
        checkOutput("rst_rready",  32'(rready),       32'd0);
        checkOutput("rst_awvalid", 32'(awvalid),      32'd0);
        checkOutput("rst_wvalid",  32'(wvalid),       32'd0);
        checkOutput("rst_bready",  32'(bready),       32'd0);
        checkOutput("rst_state",   32'(dut.state_q),  32'd0);
      end else if (lsu_over) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_over", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rdata",   lsu_rdata,          e.rdata);
          checkOutput("err",     32'(lsu_err),       32'(e.err));
          checkOutput("latency", 32'(cycle - e.issue), 32'(e.lat));
          if (e.kind == 0) begin
            checkOutput("no_ar", 32'(ar_seen), 32'(e.ar_snap));
            checkOutput("no_aw", 32'(aw_seen), 32'(e.aw_snap));
          end else begin
            checkOutput("resp_to_over", 32'(cycle), 32'(last_resp_cycle + 1));
            if (e.kind == 1) begin
              checkOutput("araddr", cap_araddr, e.addr);
              checkOutput("no_aw", 32'(aw_seen), 32'(e.aw_snap));
            end else begin
              checkOutput("awaddr", cap_awaddr, e.addr);
              checkOutput("wdata",  cap_wdata,  e.wdata);
              checkOutput("wstrb",  32'(cap_wstrb), 32'(e.wstrb));
              checkOutput("no_ar", 32'(ar_seen), 32'(e.ar_snap));
            end
          end
        end
      end else if (sb.size() != 0 && cycle > sb[0].issue + 40) begin
        e = sb.pop_front();
        checkOutput("timeout_over", 32'd0, 32'd1);
      end
    end
  end

  task automatic applyStimulus(input logic ren, input logic wen, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd, input int kind,
                               input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                               input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                               input bit extra);
    exp_t e;
    @(posedge clock); #1;
    e.kind = kind; e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.addr = a;
    e.wdata = e_wdata; e.wstrb = e_wstrb; e.issue = cycle;
    e.ar_snap = ar_seen; e.aw_snap = aw_seen;
    sb.push_back(e);
    lsu_valid = 1; lsu_ren = ren; lsu_wen = wen; funct3 = f3; addr = a; store_data = sd;
    @(posedge clock); #1;
    lsu_valid = 0; lsu_ren = 0; lsu_wen = 0;
    addr = 32'hDEAD0000; store_data = 32'h5A5A5A5A;
    if (extra) begin
      lsu_valid = 1; lsu_wen = 1;
      @(posedge clock); #1;
      lsu_valid = 0; lsu_wen = 0;
    end
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
      $fatal(1, "[TB] scoreboard did not drain");
    end
  endtask

  initial begin
    reset = 0; lsu_valid = 0; lsu_ren = 0; lsu_wen = 0;
    funct3 = 0; addr = 0; store_data = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1;

    applyStimulus(0, 0, 3'b000, 32'h00001234, 32'h0, 0, 32'h0, 0, 1, 32'h0, 4'h0, 0);

    r_data_cfg = 32'h80FF1234;
    applyStimulus(1, 0, 3'b000, 32'h80000003, 32'h0, 1, 32'hFFFFFF80, 0, 3, 32'h0, 4'h0, 0);

    aw_delay = 4;
    applyStimulus(0, 1, 3'b001, 32'h80000002, 32'h0000BEEF, 2, 32'h0, 0, 7, 32'hBEEF0000, 4'b1100, 0);
    aw_delay = 0;

    r_data_cfg = 32'h11223344; r_resp_cfg = 2'b10;
    applyStimulus(1, 0, 3'b010, 32'h80000000, 32'h0, 1, 32'h11223344, 1, 3, 32'h0, 4'h0, 0);
    r_resp_cfg = 2'b00;
    applyStimulus(1, 0, 3'b010, 32'h80000000, 32'h0, 1, 32'h11223344, 0, 3, 32'h0, 4'h0, 0);

    r_data_cfg = 32'h80FF1234;
    applyStimulus(1, 0, 3'b100, 32'h80000002, 32'h0, 1, 32'h000000FF, 0, 3, 32'h0, 4'h0, 0);
    applyStimulus(1, 0, 3'b001, 32'h80000002, 32'h0, 1, 32'hFFFF80FF, 0, 3, 32'h0, 4'h0, 0);
    applyStimulus(1, 0, 3'b101, 32'h80000000, 32'h0, 1, 32'h00001234, 0, 3, 32'h0, 4'h0, 0);

    applyStimulus(0, 1, 3'b000, 32'h80000003, 32'h123456A5, 2, 32'h0, 0, 3, 32'hA5000000, 4'b1000, 0);
    applyStimulus(0, 1, 3'b010, 32'h80000004, 32'hDEADBEEF, 2, 32'h0, 0, 3, 32'hDEADBEEF, 4'b1111, 0);

    ar_delay = 2; r_delay = 3; r_data_cfg = 32'hCAFEF00D;
    applyStimulus(1, 0, 3'b010, 32'h80000008, 32'h0, 1, 32'hCAFEF00D, 0, 8, 32'h0, 4'h0, 1);
    ar_delay = 0; r_delay = 0;

    w_delay = 2; b_resp_cfg = 2'b01;
    applyStimulus(0, 1, 3'b010, 32'h8000000C, 32'h01020304, 2, 32'h0, 1, 5, 32'h01020304, 4'b1111, 0);
    w_delay = 0; b_resp_cfg = 2'b00;

    r_delay = 5;
    @(posedge clock); #1;
    lsu_valid = 1; lsu_ren = 1; funct3 = 3'b010; addr = 32'h80000010;
    @(posedge clock); #1;
    lsu_valid = 0; lsu_ren = 0;
    for (int i = 0; i < 20; i++) begin
      if (rready) break;
      @(posedge clock); #1;
    end
    reset = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1;
    r_delay = 0;

    r_data_cfg = 32'h80FF1234;
    applyStimulus(1, 0, 3'b101, 32'h80000002, 32'h0, 1, 32'h000080FF, 0, 3, 32'h0, 4'h0, 0);

    r_data_cfg = 32'hAABBCCDD;
`ifdef LSU_MISALIGN_CHECK_EN
    applyStimulus(1, 0, 3'b010, 32'h80000001, 32'h0, 0, 32'h0, 1, 1, 32'h0, 4'h0, 0);
`else
    applyStimulus(1, 0, 3'b010, 32'h80000001, 32'h0, 1, 32'h00AABBCC, 0, 3, 32'h0, 4'h0, 0);
`endif

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
